// File: rtl/lc3_decode_pkg.sv
// LC-3 decode definitions: opcode enum, control-field encodings and E_Control bit layout.
// Pure declarations; no logic, so no latency and no backpressure.
package lc3_decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PC1_NONE  = 2'b00;
  localparam logic [1:0] PC1_OFF9  = 2'b01;
  localparam logic [1:0] PC1_OFF6  = 2'b10;
  localparam logic [1:0] PC1_ZERO  = 2'b11;

  localparam logic [1:0] W_ALU = 2'b00;
  localparam logic [1:0] W_MEM = 2'b01;
  localparam logic [1:0] W_PC  = 2'b10;

  localparam int E_ALU_HI = 5;
  localparam int E_ALU_LO = 4;
  localparam int E_PC1_HI = 3;
  localparam int E_PC1_LO = 2;
  localparam int E_PC2    = 1;
  localparam int E_OP2    = 0;

  function automatic logic [5:0] pack_e(input logic [1:0] alu, input logic [1:0] pc1,
                                        input logic pc2, input logic op2);
    logic [5:0] e;
    e                   = '0;
    e[E_ALU_HI:E_ALU_LO] = alu;
    e[E_PC1_HI:E_PC1_LO] = pc1;
    e[E_PC2]            = pc2;
    e[E_OP2]            = op2;
    return e;
  endfunction

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode decoder: opcode + IR[5] to execute/writeback/memory controls.
// Zero latency, no state, no backpressure.
module lc3_decode_ctrl
  import lc3_decode_pkg::*;
(
  input  opcode_e    opcode,
  input  logic       ir5,
  output logic [5:0] e_ctrl,
  output logic [1:0] w_ctrl,
  output logic       mem_ctrl,
  output logic       illegal
);

  always_comb begin
    e_ctrl   = '0;
    w_ctrl   = W_ALU;
    mem_ctrl = 1'b0;
    illegal  = 1'b0;
    unique case (opcode)
      OP_ADD: e_ctrl = pack_e(ALU_ADD, PC1_NONE, 1'b0, ~ir5);
      OP_AND: e_ctrl = pack_e(ALU_AND, PC1_NONE, 1'b0, ~ir5);
      OP_NOT: e_ctrl = pack_e(ALU_NOT, PC1_NONE, 1'b0, 1'b1);
      OP_BR:  e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
      OP_JMP: e_ctrl = pack_e(ALU_ADD, PC1_ZERO, 1'b0, 1'b0);
      OP_LD: begin
        e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        w_ctrl = W_MEM;
      end
      OP_LDR: begin
        e_ctrl = pack_e(ALU_ADD, PC1_OFF6, 1'b0, 1'b0);
        w_ctrl = W_MEM;
      end
      OP_LDI: begin
        e_ctrl   = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        w_ctrl   = W_MEM;
        mem_ctrl = 1'b1;
      end
      OP_LEA: begin
        e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        w_ctrl = W_PC;
      end
      OP_ST:  e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
      OP_STR: e_ctrl = pack_e(ALU_ADD, PC1_OFF6, 1'b0, 1'b0);
      OP_STI: begin
        e_ctrl   = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        mem_ctrl = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: 1-cycle registered decode on enable_decode; outputs hold when not enabled.
// Optional sticky illegal-opcode flag via LC3_DECODE_ILLEGAL_DETECT_EN.
module lc3_decode
  import lc3_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        decode_valid,
  output logic [15:0] decode_count,
  output logic        illegal_op
);

  opcode_e    op;
  logic [5:0] dec_e;
  logic [1:0] dec_w;
  logic       dec_mem;
  logic       dec_illegal;

  assign op = opcode_e'(dout[15:12]);

  lc3_decode_ctrl u_ctrl (
    .opcode   (op),
    .ir5      (dout[5]),
    .e_ctrl   (dec_e),
    .w_ctrl   (dec_w),
    .mem_ctrl (dec_mem),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      IR           <= '0;
      npc_out      <= '0;
      E_Control    <= '0;
      W_Control    <= '0;
      Mem_Control  <= 1'b0;
      decode_valid <= 1'b0;
      decode_count <= '0;
    end else begin
      decode_valid <= enable_decode;
      if (enable_decode) begin
        IR           <= dout;
        npc_out      <= npc_in;
        E_Control    <= dec_e;
        W_Control    <= dec_w;
        Mem_Control  <= dec_mem;
        decode_count <= decode_count + 16'd1;
      end
    end
  end

`ifdef LC3_DECODE_ILLEGAL_DETECT_EN
  // Sticky until reset; the instruction itself is still latched above.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      illegal_op <= 1'b0;
    else if (enable_decode && dec_illegal)
      illegal_op <= 1'b1;
  end
`else
  logic dec_illegal_unused;
  assign dec_illegal_unused = dec_illegal;
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// Self-checking bench for lc3_decode: table-driven reference model plus directed literal checks.
module tb_lc3_decode;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_decode = 1'b0;
  logic [15:0] dout = '0;
  logic [15:0] npc_in = '0;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        decode_valid;
  logic [15:0] decode_count;
  logic        illegal_op;

  int n_chk  = 0;
  int n_fail = 0;

  lc3_decode dut (
    .clock        (clock),
    .reset        (reset),
    .enable_decode(enable_decode),
    .dout         (dout),
    .npc_in       (npc_in),
    .IR           (IR),
    .npc_out      (npc_out),
    .E_Control    (E_Control),
    .W_Control    (W_Control),
    .Mem_Control  (Mem_Control),
    .decode_valid (decode_valid),
    .decode_count (decode_count),
    .illegal_op   (illegal_op)
  );

  always #5 clock = ~clock;

  // Per-opcode rule table: alu, pcsel1, pcsel2, W, Mem, op2 rule (0 zero, 1 one, 2 ~IR[5]), illegal.
  int t_alu [16];
  int t_pc1 [16];
  int t_pc2 [16];
  int t_w   [16];
  int t_mem [16];
  int t_op2 [16];
  int t_ill [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      t_alu[i] = 0; t_pc1[i] = 0; t_pc2[i] = 0; t_w[i] = 0; t_mem[i] = 0; t_op2[i] = 0; t_ill[i] = 0;
    end
    t_op2[1] = 2;                                   // ADD
    t_alu[5] = 1; t_op2[5] = 2;                     // AND
    t_alu[9] = 2; t_op2[9] = 1;                     // NOT
    t_pc1[0] = 1; t_pc2[0] = 1;                     // BR
    t_pc1[12] = 3;                                  // JMP
    t_pc1[2] = 1; t_pc2[2] = 1; t_w[2] = 1;         // LD
    t_pc1[6] = 2; t_w[6] = 1;                       // LDR
    t_pc1[10] = 1; t_pc2[10] = 1; t_w[10] = 1; t_mem[10] = 1; // LDI
    t_pc1[14] = 1; t_pc2[14] = 1; t_w[14] = 2;      // LEA
    t_pc1[3] = 1; t_pc2[3] = 1;                     // ST
    t_pc1[7] = 2;                                   // STR
    t_pc1[11] = 1; t_pc2[11] = 1; t_mem[11] = 1;    // STI
    t_ill[4] = 1; t_ill[8] = 1; t_ill[13] = 1; t_ill[15] = 1;
  end

  logic [15:0] m_ir = '0, m_npc = '0, m_cnt = '0;
  logic [5:0]  m_e = '0;
  logic [1:0]  m_w = '0;
  logic        m_mem = 1'b0, m_vld = 1'b0, m_ill = 1'b0;

  function automatic logic [5:0] model_e(input logic [15:0] instr);
    int op;
    int op2;
    op  = int'(instr[15:12]);
    op2 = (t_op2[op] == 2) ? (instr[5] ? 0 : 1) : t_op2[op];
    return 6'(t_alu[op] * 16 + t_pc1[op] * 4 + t_pc2[op] * 2 + op2);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ir <= '0; m_npc <= '0; m_cnt <= '0; m_e <= '0; m_w <= '0;
      m_mem <= 1'b0; m_vld <= 1'b0; m_ill <= 1'b0;
    end else begin
      m_vld <= enable_decode;
      if (enable_decode) begin
        m_ir  <= dout;
        m_npc <= npc_in;
        m_e   <= model_e(dout);
        m_w   <= 2'(t_w[int'(dout[15:12])]);
        m_mem <= (t_mem[int'(dout[15:12])] != 0);
        m_cnt <= m_cnt + 16'd1;
`ifdef LC3_DECODE_ILLEGAL_DETECT_EN
        if (t_ill[int'(dout[15:12])] != 0) m_ill <= 1'b1;
`endif
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("cmp_ir",    IR,                   m_ir);
    check("cmp_npc",   npc_out,              m_npc);
    check("cmp_e",     16'(E_Control),       16'(m_e));
    check("cmp_w",     16'(W_Control),       16'(m_w));
    check("cmp_mem",   16'(Mem_Control),     16'(m_mem));
    check("cmp_valid", 16'(decode_valid),    16'(m_vld));
    check("cmp_count", decode_count,         m_cnt);
    check("cmp_ill",   16'(illegal_op),      16'(m_ill));
  end

  task automatic step(input logic en, input logic [15:0] instr, input logic [15:0] npc);
    enable_decode = en;
    dout          = instr;
    npc_in        = npc;
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1: pulses reset strictly between clock edges.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_async_ir",    IR,                   16'h0000);
    check("rst_async_e",     16'(E_Control),       16'h0000);
    check("rst_async_w",     16'(W_Control),       16'h0000);
    check("rst_async_mem",   16'(Mem_Control),     16'h0000);
    check("rst_async_valid", 16'(decode_valid),    16'h0000);
    check("rst_async_count", decode_count,         16'h0000);
    check("rst_async_npc",   npc_out,              16'h0000);
    check("rst_async_ill",   16'(illegal_op),      16'h0000);
    #1 reset = 1'b0;
  endtask

  logic exp_ill_trap;

  initial begin
`ifdef LC3_DECODE_ILLEGAL_DETECT_EN
    exp_ill_trap = 1'b1;
`else
    exp_ill_trap = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_ir",    IR,                16'h0000);
    check("reset_count", decode_count,      16'h0000);
    check("reset_valid", 16'(decode_valid), 16'h0000);
    check("reset_e",     16'(E_Control),    16'h0000);

    step(1'b1, 16'h1283, 16'h3001);
    check("add_reg_ir",    IR,                16'h1283);
    check("add_reg_npc",   npc_out,           16'h3001);
    check("add_reg_e",     16'(E_Control),    16'h0001);
    check("add_reg_w",     16'(W_Control),    16'h0000);
    check("add_reg_mem",   16'(Mem_Control),  16'h0000);
    check("add_reg_valid", 16'(decode_valid), 16'h0001);
    check("add_reg_count", decode_count,      16'h0001);

    pulse_reset();
    step(1'b1, 16'h12A5, 16'h3002);
    check("add_imm_e", 16'(E_Control), 16'h0000);
    check("add_imm_w", 16'(W_Control), 16'h0000);
    step(1'b1, 16'hA005, 16'h3003);
    check("ldi_e",   16'(E_Control),   16'h0006);
    check("ldi_w",   16'(W_Control),   16'h0001);
    check("ldi_mem", 16'(Mem_Control), 16'h0001);
    step(1'b1, 16'hE00A, 16'h3004);
    check("lea_e",     16'(E_Control),   16'h0006);
    check("lea_w",     16'(W_Control),   16'h0002);
    check("lea_mem",   16'(Mem_Control), 16'h0000);
    check("b2b_count", decode_count,     16'h0003);

    step(1'b1, 16'h92BF, 16'h3005);
    check("not_e", 16'(E_Control), 16'h0021);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'(16'h5A5A + i), 16'h7777);
      check("stall_valid", 16'(decode_valid), 16'h0000);
      check("stall_ir",    IR,                16'h92BF);
      check("stall_e",     16'(E_Control),    16'h0021);
      check("stall_count", decode_count,      16'h0004);
    end
    step(1'b1, 16'hC1C0, 16'h3006);
    check("jmp_e", 16'(E_Control), 16'h000C);

    step(1'b1, 16'h7283, 16'h3007);
    check("str_e", 16'(E_Control), 16'h0008);
    pulse_reset();
    step(1'b1, 16'h1283, 16'h4001);
    check("post_rst_count", decode_count,      16'h0001);
    check("post_rst_valid", 16'(decode_valid), 16'h0001);

    step(1'b1, 16'hF025, 16'h4002);
    check("trap_ill",  16'(illegal_op),  16'(exp_ill_trap));
    check("trap_e",    16'(E_Control),   16'h0000);
    check("trap_w",    16'(W_Control),   16'h0000);
    check("trap_ir",   IR,               16'hF025);
    check("trap_count", decode_count,    16'h0002);
    step(1'b1, 16'h1283, 16'h4003);
    check("ill_sticky", 16'(illegal_op), 16'(exp_ill_trap));
    step(1'b0, 16'h0000, 16'h0000);

    pulse_reset();
    for (int i = 0; i < 65535; i++)
      step(1'b1, 16'(i * 16'h1357), 16'(i));
    check("wrap_pre", decode_count, 16'hFFFF);
    step(1'b1, 16'h5020, 16'hBEEF);
    check("wrap_count", decode_count, 16'h0000);
    check("wrap_ir",    IR,           16'h5020);
    check("wrap_e",     16'(E_Control), 16'h0010);
    step(1'b0, 16'h0000, 16'h0000);
    @(negedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
